// File: rtl/pipeline_pkg.sv
// Shared encodings for the MIPS pipeline hazard/control unit: opcodes,
// forwarding codes, per-stage control encodings and Tuse/Tnew values.
package pipeline_pkg;

    // Opcode / funct fields
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Forwarding-mux codes, shared by every select
    localparam logic [2:0] FWD_NONE  = 3'd0;
    localparam logic [2:0] FWD_AO_M  = 3'd1;
    localparam logic [2:0] FWD_PC4_M = 3'd2;
    localparam logic [2:0] FWD_AO_W  = 3'd3;
    localparam logic [2:0] FWD_DM_W  = 3'd4;
    localparam logic [2:0] FWD_PC4_W = 3'd5;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_B   = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] MTR_AO  = 2'b00;
    localparam logic [1:0] MTR_DM  = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [1:0] NPC_ADD4 = 2'b00;
    localparam logic [1:0] NPC_NPC  = 2'b01;
    localparam logic [1:0] NPC_RS   = 2'b10;

    // TUSE_NONE marks an operand that is not read; it exceeds every Tnew,
    // so it can never trigger a stall.
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;

    localparam int S_D = 0;
    localparam int S_E = 1;
    localparam int S_M = 2;
    localparam int S_W = 3;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
    } instr_class_e;

    // Decoded view of one instruction; tnew is the value while in E.
    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   a3;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [1:0]   tuse_rs;
        logic [1:0]   tuse_rt;
        logic [1:0]   tnew;
        logic [1:0]   npcsel;
        logic [1:0]   extop;
        logic         alusrc;
        logic [1:0]   aluctr;
        logic         memwrite;
        logic [1:0]   memtoreg;
    } dec_t;

    // True when reading r at Tuse cannot be satisfied by a producer with Tnew
    function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [4:0] a3, input logic [1:0] tnew);
        return (r != 5'd0) && (a3 == r) && (tuse < tnew);
    endfunction

    // Nearest-stage forward select; a matching M producer that is not yet
    // ready blocks the older W value (the stall logic covers that case).
    function automatic logic [2:0] fwd_code(input logic [4:0] r, input logic use_m,
                                            input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                            input instr_class_e cls_m,
                                            input logic [4:0] a3_w, input instr_class_e cls_w);
        logic [2:0] code;
        code = FWD_NONE;
        if (r == 5'd0) begin
            code = FWD_NONE;
        end else if (use_m && (a3_m == r)) begin
            if (tnew_m == TNEW_0)
                code = (cls_m == C_JAL) ? FWD_PC4_M : FWD_AO_M;
        end else if (a3_w == r) begin
            if (cls_w == C_JAL)     code = FWD_PC4_W;
            else if (cls_w == C_LW) code = FWD_DM_W;
            else                    code = FWD_AO_W;
        end
        return code;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_instr_decode.sv
// Combinational decoder for one pipeline stage: class, A3, source fields,
// Tuse/Tnew and every per-stage control line.
module instr_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    instr_class_e cls;

    // Classify the instruction word; anything unrecognised behaves as nop
    always_comb begin
        cls = C_NOP;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU: cls = C_ADDU;
                    FN_SUBU: cls = C_SUBU;
                    FN_JR:   cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

    // Derive destination, operand timing and stage controls from the class
    always_comb begin
        dec         = '0;
        dec.cls     = cls;
        dec.rs      = ir[25:21];
        dec.rt      = ir[20:16];
        dec.tuse_rs = TUSE_NONE;
        dec.tuse_rt = TUSE_NONE;
        dec.tnew    = TNEW_0;
        case (cls)
            C_ADDU, C_SUBU: begin
                dec.a3      = ir[15:11];
                dec.tuse_rs = TUSE_1;
                dec.tuse_rt = TUSE_1;
                dec.tnew    = TNEW_1;
                dec.aluctr  = (cls == C_SUBU) ? ALU_SUB : ALU_ADD;
            end
            C_ORI: begin
                dec.a3      = ir[20:16];
                dec.tuse_rs = TUSE_1;
                dec.tnew    = TNEW_1;
                dec.extop   = EXT_ZERO;
                dec.alusrc  = 1'b1;
                dec.aluctr  = ALU_OR;
            end
            C_LUI: begin
                dec.a3      = ir[20:16];
                dec.tnew    = TNEW_1;
                dec.extop   = EXT_LUI;
                dec.alusrc  = 1'b1;
                dec.aluctr  = ALU_B;
            end
            C_LW: begin
                dec.a3       = ir[20:16];
                dec.tuse_rs  = TUSE_1;
                dec.tnew     = TNEW_2;
                dec.extop    = EXT_SIGN;
                dec.alusrc   = 1'b1;
                dec.memtoreg = MTR_DM;
            end
            C_SW: begin
                dec.tuse_rs  = TUSE_1;
                dec.tuse_rt  = TUSE_2;
                dec.extop    = EXT_SIGN;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            C_BEQ: begin
                dec.tuse_rs = TUSE_0;
                dec.tuse_rt = TUSE_0;
                dec.extop   = EXT_SIGN;
                dec.npcsel  = NPC_NPC;
            end
            C_J: begin
                dec.npcsel = NPC_NPC;
            end
            C_JAL: begin
                dec.a3       = 5'd31;
                dec.tnew     = TNEW_1;
                dec.npcsel   = NPC_NPC;
                dec.memtoreg = MTR_PC4;
            end
            C_JR: begin
                dec.tuse_rs = TUSE_0;
                dec.npcsel  = NPC_RS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and control unit for the five-stage MIPS pipeline. Keeps shadow
// copies of the instruction in E/M/W, decodes all four stages, and derives
// stall and forwarding selects from Tuse/Tnew.
module pipeline_ctrl
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        beq,
    output logic        j,
    output logic        jal,
    output logic [1:0]  npcsel,
    output logic [1:0]  EXTop,
    output logic        ALUSrc,
    output logic [1:0]  ALUctr,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic [4:0]  A3_W,
    output logic [2:0]  MCMP1D,
    output logic [2:0]  MCMP2D,
    output logic [2:0]  MALUAE,
    output logic [2:0]  MALUBE,
    output logic [2:0]  MWDM,
    output logic        enPC,
    output logic        enD,
    output logic        clrE
);

    logic [31:0]       ir_e, ir_m, ir_w;
    logic [3:0][31:0]  ir;
    dec_t [3:0]        dec;
    logic [1:0]        tnew_m;
    logic              stall;

    assign ir = {ir_w, ir_m, ir_e, IR_D};

    for (genvar s = 0; s < 4; s++) begin : g_dec
        instr_decode u_dec (
            .ir  (ir[s]),
            .dec (dec[s])
        );
    end

    // One cycle later every producer is one step closer to its result
    assign tnew_m = (dec[S_M].tnew == TNEW_0) ? TNEW_0 : dec[S_M].tnew - 2'd1;

    assign stall = hazard(dec[S_D].rs, dec[S_D].tuse_rs, dec[S_E].a3, dec[S_E].tnew)
                 | hazard(dec[S_D].rs, dec[S_D].tuse_rs, dec[S_M].a3, tnew_m)
                 | hazard(dec[S_D].rt, dec[S_D].tuse_rt, dec[S_E].a3, dec[S_E].tnew)
                 | hazard(dec[S_D].rt, dec[S_D].tuse_rt, dec[S_M].a3, tnew_m);

    // Shadow pipeline; a stall turns the E slot into a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_e <= '0;
            ir_m <= '0;
            ir_w <= '0;
        end else begin
            ir_e <= stall ? '0 : IR_D;
            ir_m <= ir_e;
            ir_w <= ir_m;
        end
    end

    assign enPC = ~stall;
    assign enD  = ~stall;
    assign clrE = stall;

    assign beq    = (dec[S_D].cls == C_BEQ);
    assign j      = (dec[S_D].cls == C_J);
    assign jal    = (dec[S_D].cls == C_JAL);
    assign npcsel = dec[S_D].npcsel;
    assign EXTop  = dec[S_D].extop;

    assign ALUSrc   = dec[S_E].alusrc;
    assign ALUctr   = dec[S_E].aluctr;
    assign MemWrite = dec[S_M].memwrite;

    assign RegWrite = (dec[S_W].a3 != 5'd0);
    assign MemtoReg = dec[S_W].memtoreg;
    assign A3_W     = dec[S_W].a3;

    assign MCMP1D = fwd_code(dec[S_D].rs, 1'b1, dec[S_M].a3, tnew_m, dec[S_M].cls,
                             dec[S_W].a3, dec[S_W].cls);
    assign MCMP2D = fwd_code(dec[S_D].rt, 1'b1, dec[S_M].a3, tnew_m, dec[S_M].cls,
                             dec[S_W].a3, dec[S_W].cls);
    assign MALUAE = fwd_code(dec[S_E].rs, 1'b1, dec[S_M].a3, tnew_m, dec[S_M].cls,
                             dec[S_W].a3, dec[S_W].cls);
    assign MALUBE = fwd_code(dec[S_E].rt, 1'b1, dec[S_M].a3, tnew_m, dec[S_M].cls,
                             dec[S_W].a3, dec[S_W].cls);
    // Store data is needed at the end of M, so only W can supply it
    assign MWDM   = fwd_code(dec[S_M].rt, 1'b0, dec[S_M].a3, tnew_m, dec[S_M].cls,
                             dec[S_W].a3, dec[S_W].cls);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver feeds instructions (held
// while the model says D is stalled) and pushes expected outputs; a monitor
// pops and compares on every falling edge.
module tb_pipeline_ctrl;

    logic        clk, reset;
    logic [31:0] IR_D;
    logic        beq, j, jal, ALUSrc, MemWrite, RegWrite, enPC, enD, clrE;
    logic [1:0]  npcsel, EXTop, ALUctr, MemtoReg;
    logic [4:0]  A3_W;
    logic [2:0]  MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .IR_D(IR_D),
        .beq(beq), .j(j), .jal(jal), .npcsel(npcsel), .EXTop(EXTop),
        .ALUSrc(ALUSrc), .ALUctr(ALUctr), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .A3_W(A3_W),
        .MCMP1D(MCMP1D), .MCMP2D(MCMP2D), .MALUAE(MALUAE), .MALUBE(MALUBE),
        .MWDM(MWDM), .enPC(enPC), .enD(enD), .clrE(clrE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       beq, j, jal;
        logic [1:0] npcsel, extop;
        logic       alusrc;
        logic [1:0] aluctr;
        logic       memwrite, regwrite;
        logic [1:0] memtoreg;
        logic [4:0] a3w;
        logic [2:0] c1, c2, ae, be, wdm;
        logic       enpc, en_d, clre;
    } out_t;

    typedef enum {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR} kind_e;

    out_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_d, m_e, m_m, m_w;
    bit          m_stall, m_rst_low;

    // ---------------- reference model ----------------
    function automatic kind_e kind_of(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                if (w[5:0] == 6'h21) return K_ADDU;
                if (w[5:0] == 6'h23) return K_SUBU;
                if (w[5:0] == 6'h08) return K_JR;
                return K_NOP;
            end
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int dst(input logic [31:0] w);
        case (kind_of(w))
            K_ADDU, K_SUBU:     return int'(w[15:11]);
            K_ORI, K_LUI, K_LW: return int'(w[20:16]);
            K_JAL:              return 31;
            default:            return 0;
        endcase
    endfunction

    // 9 = operand not read
    function automatic int use_rs(input kind_e k);
        if (k == K_BEQ || k == K_JR) return 0;
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW}) return 1;
        return 9;
    endfunction

    function automatic int use_rt(input kind_e k);
        if (k == K_BEQ) return 0;
        if (k == K_ADDU || k == K_SUBU) return 1;
        if (k == K_SW) return 2;
        return 9;
    endfunction

    // cycles until the result exists, for a producer sitting in E (in_m=0) or M
    function automatic int ready_in(input kind_e k, input bit in_m);
        if (in_m) return (k == K_LW) ? 1 : 0;
        if (k == K_LW) return 2;
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_JAL}) return 1;
        return 0;
    endfunction

    function automatic bit blocked(input int r, input int tuse);
        if (r == 0 || tuse == 9) return 0;
        if (dst(m_e) == r && tuse < ready_in(kind_of(m_e), 0)) return 1;
        if (dst(m_m) == r && tuse < ready_in(kind_of(m_m), 1)) return 1;
        return 0;
    endfunction

    function automatic logic [2:0] fwd(input int r, input bit look_m);
        if (r == 0) return 0;
        if (look_m && dst(m_m) == r)
            return (ready_in(kind_of(m_m), 1) != 0) ? 3'd0 : (kind_of(m_m) == K_JAL ? 3'd2 : 3'd1);
        if (dst(m_w) == r) begin
            if (kind_of(m_w) == K_JAL) return 5;
            if (kind_of(m_w) == K_LW)  return 4;
            return 3;
        end
        return 0;
    endfunction

    function automatic out_t model_eval();
        out_t  o;
        kind_e kd, ke, km, kw;
        kd = kind_of(m_d); ke = kind_of(m_e); km = kind_of(m_m); kw = kind_of(m_w);
        o = '0;
        o.beq    = (kd == K_BEQ);
        o.j      = (kd == K_J);
        o.jal    = (kd == K_JAL);
        o.npcsel = (kd inside {K_BEQ, K_J, K_JAL}) ? 2'b01 : (kd == K_JR ? 2'b10 : 2'b00);
        o.extop  = (kd inside {K_LW, K_SW, K_BEQ}) ? 2'b01 : (kd == K_LUI ? 2'b10 : 2'b00);
        o.alusrc = (ke inside {K_ORI, K_LUI, K_LW, K_SW});
        o.aluctr = (ke == K_SUBU) ? 2'b01 : (ke == K_ORI) ? 2'b10 : (ke == K_LUI) ? 2'b11 : 2'b00;
        o.memwrite = (km == K_SW);
        o.regwrite = (dst(m_w) != 0);
        o.memtoreg = (kw == K_LW) ? 2'b01 : (kw == K_JAL ? 2'b10 : 2'b00);
        o.a3w  = 5'(dst(m_w));
        o.c1   = fwd(int'(m_d[25:21]), 1);
        o.c2   = fwd(int'(m_d[20:16]), 1);
        o.ae   = fwd(int'(m_e[25:21]), 1);
        o.be   = fwd(int'(m_e[20:16]), 1);
        o.wdm  = fwd(int'(m_m[20:16]), 0);
        m_stall = blocked(int'(m_d[25:21]), use_rs(kd)) || blocked(int'(m_d[20:16]), use_rt(kd));
        o.enpc = !m_stall;
        o.en_d = !m_stall;
        o.clre = m_stall;
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] w, input logic rst_v);
        @(posedge clk);
        if (m_rst_low) begin
            m_e = 0; m_m = 0; m_w = 0;
        end else begin
            m_w = m_m; m_m = m_e; m_e = m_stall ? 32'd0 : m_d;
        end
        #1;
        IR_D = w; reset = rst_v; m_d = w; m_rst_low = !rst_v;
        if (!rst_v) begin m_e = 0; m_m = 0; m_w = 0; end
        exp_q.push_back(model_eval());
    endtask

    task automatic issue(input logic [31:0] w, output int stalls);
        stalls = 0;
        step(w, 1'b1);
        #1 if (!enPC) stalls++;
        for (int k = 0; k < 4 && m_stall; k++) begin
            step(w, 1'b1);
            #1 if (!enPC) stalls++;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) step(32'd0, 1'b1);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] pool [5];
        logic [4:0] a, b, c;
        logic [15:0] imm;
        pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 3; pool[4] = 31;
        a = pool[$urandom_range(0, 4)];
        b = pool[$urandom_range(0, 4)];
        c = pool[$urandom_range(0, 4)];
        imm = 16'($urandom);
        case ($urandom_range(0, 11))
            0:  return {6'h00, a, b, c, 5'd0, 6'h21};
            1:  return {6'h00, a, b, c, 5'd0, 6'h23};
            2:  return {6'h0d, a, b, imm};
            3:  return {6'h0f, 5'd0, b, imm};
            4:  return {6'h23, a, b, imm};
            5:  return {6'h2b, a, b, imm};
            6:  return {6'h04, a, b, imm};
            7:  return {6'h02, 26'($urandom)};
            8:  return {6'h03, 26'($urandom)};
            9:  return {6'h00, a, 15'd0, 6'h08};
            10: return 32'd0;
            default: return {6'h3f, a, b, imm};
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        out_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{beq, j, jal, npcsel, EXTop, ALUSrc, ALUctr, MemWrite, RegWrite,
                      MemtoReg, A3_W, MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM, enPC, enD, clrE};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t IR_D=%h: got %h expected %h", $time, IR_D, a, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        reset = 1'b0; IR_D = 32'd0;
        m_d = 0; m_e = 0; m_m = 0; m_w = 0; m_stall = 0; m_rst_low = 1;
        step(32'd0, 1'b0);
        step(32'd0, 1'b0);
        #1 chk("reset enPC", int'(enPC), 1);
        chk("reset RegWrite", int'(RegWrite), 0);
        step(32'd0, 1'b1);

        // ALU-to-ALU forwarding
        issue(32'h34010005, s);
        issue(32'h00211021, s); chk("alu_alu stalls", s, 0);
        step(32'd0, 1'b1);
        #1 chk("alu_alu MALUAE", int'(MALUAE), 1);
        chk("alu_alu MALUBE", int'(MALUBE), 1);
        drain();

        // Load-use
        issue(32'h8C010000, s);
        issue(32'h00201021, s); chk("load_use stalls", s, 1);
        step(32'd0, 1'b1);
        #1 chk("load_use MALUAE", int'(MALUAE), 4);
        drain();

        // Load then branch
        issue(32'h8C010000, s);
        issue(32'h10210000, s); chk("lw_beq stalls", s, 2);
        chk("lw_beq MCMP1D", int'(MCMP1D), 4);
        chk("lw_beq MCMP2D", int'(MCMP2D), 4);
        chk("lw_beq beq", int'(beq), 1);
        chk("lw_beq npcsel", int'(npcsel), 1);
        drain();

        // jal then jr $31
        issue(32'h0C000000, s);
        issue(32'h03E00008, s); chk("jal_jr stalls", s, 1);
        chk("jal_jr MCMP1D", int'(MCMP1D), 2);
        chk("jal_jr npcsel", int'(npcsel), 2);
        step(32'd0, 1'b1);
        #1 chk("jal W A3_W", int'(A3_W), 31);
        chk("jal W MemtoReg", int'(MemtoReg), 2);
        chk("jal W RegWrite", int'(RegWrite), 1);
        drain();

        // Store-data forwarding
        issue(32'h8C030000, s);
        issue(32'hAC030000, s); chk("lw_sw stalls", s, 0);
        step(32'd0, 1'b1);
        step(32'd0, 1'b1);
        #1 chk("lw_sw MWDM", int'(MWDM), 4);
        drain();

        // $0 is never a hazard
        issue(32'h34000001, s);
        issue(32'h00001021, s); chk("zero_reg stalls", s, 0);
        step(32'd0, 1'b1);
        #1 chk("zero_reg MALUAE", int'(MALUAE), 0);
        chk("zero_reg MALUBE", int'(MALUBE), 0);
        drain();

        // Reset asserted in the load-use stall cycle
        issue(32'h8C010000, s);
        step(32'h00201021, 1'b1);
        #1 chk("pre_reset clrE", int'(clrE), 1);
        @(negedge clk); #1;
        reset = 1'b0; m_rst_low = 1; m_e = 0; m_m = 0; m_w = 0;
        void'(model_eval());
        #1 chk("mid_reset enPC", int'(enPC), 1);
        chk("mid_reset clrE", int'(clrE), 0);
        chk("mid_reset RegWrite", int'(RegWrite), 0);
        chk("mid_reset MemWrite", int'(MemWrite), 0);
        chk("mid_reset selects", int'({MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM}), 0);
        step(32'd0, 1'b0);
        step(32'd0, 1'b1);

        // Randomized traffic over a small register pool
        for (int n = 0; n < 400; n++) issue(rnd_instr(), s);
        drain();

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
